// File: rtl/nibble_serial_add.sv
// Wide unsigned adder that reuses one 4-bit ripple adder,
// one nibble per clock, LSB nibble first.
module add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[4];
  end
endmodule

module nibble_serial_add #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 ci,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 co
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [IW-1:0]  idx;
  logic           carry;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   part;
  logic [W-1:0]   part_nx;
  logic [3:0]     a_nib;
  logic [3:0]     b_nib;
  logic [3:0]     s_nib;
  logic           c_nib;
  logic           last;
  logic           accept;
  logic           running;

  assign running = (state == RUN);
  assign busy    = running;
  assign accept  = (state == IDLE) && start;
  assign last    = (idx == IW'(NIBBLES - 1));

  // nibble select by compare keeps index widths exact
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx == IW'(k)) begin
        a_nib = a_reg[4*k +: 4];
        b_nib = b_reg[4*k +: 4];
      end
    end
  end

  add4 u_add4 (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry),
    .s  (s_nib),
    .co (c_nib)
  );

  always_comb begin
    part_nx = part;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx == IW'(k)) begin
        part_nx[4*k +: 4] = s_nib;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= running && last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      part  <= '0;
      idx   <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      idx   <= '0;
      carry <= ci;
    end else if (running) begin
      part  <= part_nx;
      carry <= c_nib;
      idx   <= last ? '0 : idx + 1'b1;
    end
  end

  // results hold through RUN; only the finishing edge updates them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      co  <= 1'b0;
    end else if (running && last) begin
      sum <= part_nx;
      co  <= c_nib;
    end
  end
endmodule

// File: tb/tb_nibble_serial_add.sv
// Bench for nibble_serial_add: wide (4 nibble) and 1 nibble
// builds against a transaction-level model.
module tb_nibble_serial_add;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        co;

  logic        start1;
  logic [3:0]  a1;
  logic [3:0]  b1;
  logic        ci1;
  logic        busy1;
  logic        done1;
  logic [3:0]  sum1;
  logic        co1;

  int passed;
  int total;
  bit cmp_on;

  nibble_serial_add #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
  );

  nibble_serial_add #(.NIBBLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .ci    (ci1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .co    (co1)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
  endtask

  // Model: an accepted add yields a+b+ci, published N edges later.
  int          rem4, rem1;
  logic [16:0] res4;
  logic [4:0]  res1;
  logic [15:0] m_sum4;
  logic        m_co4, m_done4;
  logic [3:0]  m_sum1;
  logic        m_co1, m_done1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem4 = 0; res4 = '0; m_sum4 = '0; m_co4 = 0; m_done4 = 0;
      rem1 = 0; res1 = '0; m_sum1 = '0; m_co1 = 0; m_done1 = 0;
    end else begin
      m_done4 = 0;
      if (rem4 > 0) begin
        rem4--;
        if (rem4 == 0) begin
          m_sum4 = res4[15:0]; m_co4 = res4[16]; m_done4 = 1;
        end
      end else if (start) begin
        res4 = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        rem4 = 4;
      end
      m_done1 = 0;
      if (rem1 > 0) begin
        rem1--;
        if (rem1 == 0) begin
          m_sum1 = res1[3:0]; m_co1 = res1[4]; m_done1 = 1;
        end
      end else if (start1) begin
        res1 = {1'b0, a1} + {1'b0, b1} + {4'd0, ci1};
        rem1 = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("busy4", busy, rem4 > 0);
      chk("done4", done, m_done4);
      chk("sum4", sum, m_sum4);
      chk("co4", co, m_co4);
      chk("busy1", busy1, rem1 > 0);
      chk("done1", done1, m_done1);
      chk("sum1", sum1, m_sum1);
      chk("co1", co1, m_co1);
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic go(input logic [15:0] x, input logic [15:0] y,
                    input logic c, input string nm);
    int k;
    a = x; b = y; ci = c; start = 1;
    @(negedge clk);
    start = 0;
    k = 1;
    while (!done && k <= 12) begin
      @(negedge clk);
      if (!done) k++;
    end
    chk({nm, "_latency"}, k, 4);
  endtask

  int ndone;

  initial begin
    passed = 0; total = 0; cmp_on = 0;
    rst_n = 0; start = 0; a = '0; b = '0; ci = 0;
    start1 = 0; a1 = '0; b1 = '0; ci1 = 0;
    @(negedge clk);
    cmp_on = 1;
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    go(16'h1234, 16'h4321, 0, "basic");
    chk("basic_sum", sum, 16'h5555);
    chk("basic_co", co, 0);

    go(16'hFFFF, 16'h0001, 0, "chain1");
    chk("chain1_sum", sum, 16'h0000);
    chk("chain1_co", co, 1);
    go(16'hFFFF, 16'hFFFF, 1, "chain2");
    chk("chain2_sum", sum, 16'hFFFF);
    chk("chain2_co", co, 1);

    // start while busy is ignored
    a = 16'h0001; b = 16'h0001; ci = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h1111; start = 1;
    @(negedge clk);
    start = 0;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("busy_ign_ndone", ndone, 1);
    chk("busy_ign_sum", sum, 16'h0002);

    // back-to-back through the done cycle
    go(16'h00FF, 16'h0001, 0, "b2b1");
    chk("b2b1_sum", sum, 16'h0100);
    chk("b2b1_co", co, 0);
    go(16'h8000, 16'h8000, 0, "b2b2");
    chk("b2b2_sum", sum, 16'h0000);
    chk("b2b2_co", co, 1);

    // reset mid-operation
    go(16'h1234, 16'h4321, 0, "pre_rst");
    chk("pre_rst_sum", sum, 16'h5555);
    a = 16'h1234; b = 16'h1111; ci = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_sum", sum, 0);
    chk("arst_co", co, 0);
    @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    go(16'h1234, 16'h1111, 0, "post_rst");
    chk("post_rst_sum", sum, 16'h2345);

    // single-nibble build
    a1 = 4'h9; b1 = 4'h8; ci1 = 1; start1 = 1;
    @(negedge clk);
    start1 = 0;
    chk("n1_busy", busy1, 1);
    @(negedge clk);
    chk("n1_done", done1, 1);
    chk("n1_sum", sum1, 4'h2);
    chk("n1_co", co1, 1);

    // random traffic on both builds
    repeat (400) begin
      @(negedge clk);
      start  = ($urandom_range(0, 2) == 0);
      a      = 16'($urandom);
      b      = 16'($urandom);
      ci     = 1'($urandom);
      start1 = ($urandom_range(0, 1) == 0);
      a1     = 4'($urandom);
      b1     = 4'($urandom);
      ci1    = 1'($urandom);
    end
    start = 0; start1 = 0;
    repeat (8) @(negedge clk);
    cmp_on = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
